activation_cache: RTL
=====================

# activation_cache

Dilation activation cache that sits between two `conv1d` layers. It captures each 4-channel result vector produced by the upstream layer (`out_d0..3` / `out_v`) and presents the four dilated taps (t-3D, t-2D, t-D, t) that the downstream layer consumes on `a0_*..a3_*`. It is the producer side of the conv1d tap interface. Together with the upstream layer's output stage it forms the cached dilated causal convolution datapath.

## Interface
- `W`, 16, sample width (signed fixed point, 4.12 as used by conv1d).
- `DILATION`, 1, tap spacing D in samples; legal range 1..64.
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high; clock `clk`.
- `in_d0..in_d3`  in  W each  upstream channel values (signed).
- `in_v`  in  1  upstream valid; level signal, may stay high indefinitely.
- `a0_d0..a0_d3`  out  W each  tap t-3D (oldest), channels 0..3.
- `a1_d0..a1_d3`  out  W each  tap t-2D.
- `a2_d0..a2_d3`  out  W each  tap t-D.
- `a3_d0..a3_d3`  out  W each  tap t (newest).
- `out_v`  out  1  one-cycle pulse: the tap set was updated in this cycle.

## Operation
- Ring buffer of DEPTH = 3*D+1 entries of 4×W bits. Write pointer `wp` runs 0..DEPTH-1 and wraps to 0.
- Capture event: `in_v & ~in_v_q`, where `in_v_q` is `in_v` registered. Exactly one capture occurs per rising edge of `in_v`, because upstream valid is sticky. An `in_v` held high produces no further captures.
- On a capture edge, all of the following happen together:
  - `mem[wp] <= in`
  - `a3 <= in` (bypass)
  - `a2 <= mem[(wp-D) mod DEPTH]`
  - `a1 <= mem[(wp-2D) mod DEPTH]`
  - `a0 <= mem[(wp+1) mod DEPTH]` (equal to wp-3D)
  - `wp <= wp+1`, with wrap
  - `out_v <= 1`
- All reads use pre-write memory contents. There is no read/write collision, because no read index equals `wp`.
- On a non-capture edge: `out_v <= 0`, and the taps hold their values.
- Zero padding is causal: a tap that refers to a sample before the first capture reads 0, because memory is reset to zero.
- Values pass through unmodified. There is no arithmetic, saturation or sign manipulation.

## Timing
- Reset values:
  - all `a*_d*` = 0
  - `out_v` = 0
  - `wp` = 0
  - `in_v_q` = 0
  - all memory entries = 0
- Reset mid-operation clears the history completely. The next capture behaves as the first sample.
- If `in_v` is already high at the first edge after reset release, that edge is a capture, because `in_v_q` resets to 0.
- Latency: with `in_v` rising before edge n, the taps and `out_v` are valid from edge n to edge n+1. `out_v` is high for exactly that one cycle.
- Minimum spacing between captures is 2 cycles, inherent to edge detection. Captures are back-to-back when `in_v` toggles every cycle.
- Pointer wrap: the capture at `wp` = DEPTH-1 sets `wp` to 0. Tap indices use modular arithmetic across the wrap.

## Configuration
- Macro: `ACTIVATION_CACHE_PRIME_EN`.
- Defined: adds a saturating fill counter (0..DEPTH). `out_v` is suppressed until DEPTH captures have occurred. The first `out_v` fires on capture DEPTH, and on every capture after that. Taps still update on every capture. The counter resets to 0.
- Undefined: `out_v` fires on every capture from the first, with zero padding. There is no counter.

## Structure
- Shared package `conv_pkg`:
  - `localparam W = 16`
  - `NUM_CH = 4`
  - `NUM_TAPS = 4`
  - `typedef logic signed [W-1:0] act_t`
  - `typedef act_t [NUM_CH-1:0] act_vec_t`
- Sub-module `act_ring_ram`:
  - parameter `DEPTH`; one synchronous write port and three asynchronous read ports (indices supplied by the parent)
  - async reset to zero
- The top level owns the edge detect, the pointer and its modular index arithmetic, the tap registers, `out_v` and the optional fill counter.

## Test plan
- D=2 (DEPTH 7). Sample s drives all channels = s. Capture s=1,2,3 → after s=3: a3=3, a2=1, a1=0, a0=0, with one `out_v` pulse per capture.
- D=2, continue to s=7 → a3=7, a2=5, a1=3, a0=1. Then s=8 (wrap, `wp` 0) → a3=8, a2=6, a1=4, a0=2.
- `in_v` held high for 10 cycles after a single rise → exactly one capture, a single `out_v` pulse, taps unchanged afterwards.
- After s=5 with D=2, assert `rst` mid-stream. Check: all taps 0 and `out_v`=0 immediately (asynchronously). Then capture s=9 → a3=9, a2=a1=a0=0.
- D=1 (DEPTH 4), `in_v` toggling every cycle with s=1..6 → after s=6: a3=6, a2=5, a1=4, a0=3, with `out_v` high every other cycle.
- With `ACTIVATION_CACHE_PRIME_EN`, D=2 → no `out_v` for s=1..6. The first `out_v` comes at s=7 with a0=1. Without the macro, the first `out_v` comes at s=1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing for the conv1d datapath: sample width, channel and tap counts.
package conv_pkg;

    localparam int W        = 16;
    localparam int NUM_CH   = 4;
    localparam int NUM_TAPS = 4;

    typedef logic signed [W-1:0] act_t;
    typedef act_t [NUM_CH-1:0]   act_vec_t;

endpackage

// File: rtl/act_ring_ram.sv
// History ring for the activation cache: one synchronous write port, three
// asynchronous read ports, whole array cleared by asynchronous reset.
module act_ring_ram #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage: reset to zero so taps before the first sample read as causal padding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/activation_cache.sv
// Dilation activation cache: captures one 4-channel vector per rising edge of in_v and
// presents taps t-3D..t. Optional macro ACTIVATION_CACHE_PRIME_EN gates out_v until the ring is full.
module activation_cache
    import conv_pkg::*;
#(
    parameter int W        = 16,
    parameter int DILATION = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_d0,
    input  logic [W-1:0] in_d1,
    input  logic [W-1:0] in_d2,
    input  logic [W-1:0] in_d3,
    input  logic         in_v,
    output logic [W-1:0] a0_d0,
    output logic [W-1:0] a0_d1,
    output logic [W-1:0] a0_d2,
    output logic [W-1:0] a0_d3,
    output logic [W-1:0] a1_d0,
    output logic [W-1:0] a1_d1,
    output logic [W-1:0] a1_d2,
    output logic [W-1:0] a1_d3,
    output logic [W-1:0] a2_d0,
    output logic [W-1:0] a2_d1,
    output logic [W-1:0] a2_d2,
    output logic [W-1:0] a2_d3,
    output logic [W-1:0] a3_d0,
    output logic [W-1:0] a3_d1,
    output logic [W-1:0] a3_d2,
    output logic [W-1:0] a3_d3,
    output logic         out_v
);

    localparam int DEPTH = 3 * DILATION + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int XW    = PW + 1;
    localparam int VW    = NUM_CH * W;

    // Modular add for an offset in 1..DEPTH-1; one conditional subtract suffices.
    function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] base, input int off);
        logic [XW-1:0] sum;
        sum = {1'b0, base} + XW'(off);
        if (sum >= XW'(DEPTH)) begin
            sum = sum - XW'(DEPTH);
        end else begin
            sum = sum;
        end
        return sum[PW-1:0];
    endfunction

    logic          in_v_q_r;
    logic [PW-1:0] wp_r;
    logic          out_v_r;
    logic [VW-1:0] taps_r [NUM_TAPS];

    logic          capture_s;
    logic          prime_ok_s;
    logic [VW-1:0] in_vec_s;
    logic [PW-1:0] idx_d_s;
    logic [PW-1:0] idx_2d_s;
    logic [PW-1:0] idx_next_s;
    logic [VW-1:0] rd_3d_s;
    logic [VW-1:0] rd_2d_s;
    logic [VW-1:0] rd_d_s;

    // Edge detect and tap read indices; wp+1 doubles as the t-3D slot and the next pointer.
    always_comb begin
        capture_s  = in_v & ~in_v_q_r;
        in_vec_s   = {in_d3, in_d2, in_d1, in_d0};
        idx_d_s    = ring_add(wp_r, DEPTH - DILATION);
        idx_2d_s   = ring_add(wp_r, DEPTH - 2 * DILATION);
        idx_next_s = ring_add(wp_r, 1);
    end

    act_ring_ram #(
        .DEPTH (DEPTH),
        .DW    (VW),
        .AW    (PW)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .we     (capture_s),
        .waddr  (wp_r),
        .wdata  (in_vec_s),
        .raddr0 (idx_next_s),
        .raddr1 (idx_2d_s),
        .raddr2 (idx_d_s),
        .rdata0 (rd_3d_s),
        .rdata1 (rd_2d_s),
        .rdata2 (rd_d_s)
    );

`ifdef ACTIVATION_CACHE_PRIME_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] fill_cnt_r;

    // Saturating count of captures since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_r <= '0;
        end else if (capture_s && (fill_cnt_r != CW'(DEPTH))) begin
            fill_cnt_r <= fill_cnt_r + CW'(1);
        end else begin
            fill_cnt_r <= fill_cnt_r;
        end
    end

    // The capture that brings the count to DEPTH is the first reported one.
    assign prime_ok_s = (fill_cnt_r >= CW'(DEPTH - 1));
`else
    assign prime_ok_s = 1'b1;
`endif

    // Pointer, tap registers and the update pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_q_r <= 1'b0;
            wp_r     <= '0;
            out_v_r  <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps_r[i] <= '0;
            end
        end else begin
            in_v_q_r <= in_v;
            out_v_r  <= capture_s & prime_ok_s;
            if (capture_s) begin
                taps_r[0] <= rd_3d_s;
                taps_r[1] <= rd_2d_s;
                taps_r[2] <= rd_d_s;
                taps_r[3] <= in_vec_s;
                wp_r      <= idx_next_s;
            end
        end
    end

    assign out_v = out_v_r;

    assign a0_d0 = taps_r[0][0*W +: W];
    assign a0_d1 = taps_r[0][1*W +: W];
    assign a0_d2 = taps_r[0][2*W +: W];
    assign a0_d3 = taps_r[0][3*W +: W];
    assign a1_d0 = taps_r[1][0*W +: W];
    assign a1_d1 = taps_r[1][1*W +: W];
    assign a1_d2 = taps_r[1][2*W +: W];
    assign a1_d3 = taps_r[1][3*W +: W];
    assign a2_d0 = taps_r[2][0*W +: W];
    assign a2_d1 = taps_r[2][1*W +: W];
    assign a2_d2 = taps_r[2][2*W +: W];
    assign a2_d3 = taps_r[2][3*W +: W];
    assign a3_d0 = taps_r[3][0*W +: W];
    assign a3_d1 = taps_r[3][1*W +: W];
    assign a3_d2 = taps_r[3][2*W +: W];
    assign a3_d3 = taps_r[3][3*W +: W];

endmodule
